lights_seq: RTL and testbench

LIGHTS_SEQ -- requirements
Module: lights_seq

---
 rtl/lights_seq_if.sv | 25 ++
 rtl/lights_seq.sv | 99 +++++++++
 tb/tb_lights_seq.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/lights_seq_if.sv
// Purpose: request/status bundle between a step-request source and lights_seq.
// Ports:   master drives man_req, burst_go, burst_len, auto_en, period;
//          slave (lights_seq) drives button, grant, busy, burst_drop, step_cnt.
interface lights_seq_if;
  logic       man_req;
  logic       burst_go;
  logic [3:0] burst_len;
  logic       auto_en;
  logic [7:0] period;
  logic       button;
  logic [1:0] grant;
  logic       busy;
  logic       burst_drop;
  logic [7:0] step_cnt;

  modport master (
    output man_req, burst_go, burst_len, auto_en, period,
    input  button, grant, busy, burst_drop, step_cnt
  );

  modport slave (
    input  man_req, burst_go, burst_len, auto_en, period,
    output button, grant, busy, burst_drop, step_cnt
  );
endinterface

// File: rtl/lights_seq.sv
// Purpose: arbitrates manual / burst / auto step requesters (priority in that
//          order) and drives a registered button strobe to the lights datapath.
// Ports:   clk, rst_n (async active-low); bus (lights_seq_if.slave) carries the
//          requests in and button/grant/busy/burst_drop/step_cnt out.
//          Every output is registered: requests seen at edge n show at edge n.
module lights_seq (
  input  logic         clk,
  input  logic         rst_n,
  lights_seq_if.slave  bus
);

  // grant code doubles as the state encoding
  localparam logic [1:0] S_IDLE   = 2'b00;
  localparam logic [1:0] S_MANUAL = 2'b01;
  localparam logic [1:0] S_BURST  = 2'b10;
  localparam logic [1:0] S_AUTO   = 2'b11;

  logic [1:0] state_q, state_d;
  logic [3:0] rem_q, rem_d;
  logic [7:0] timer_q, timer_d;
  logic [7:0] step_q, step_d;
  logic       button_q, button_d;
  logic       busy_q, busy_d;
  logic       drop_q, drop_d;

  logic       burst_acc;
  logic [3:0] rem_eff;
  logic       auto_ok;
  logic       auto_win;
  logic       auto_fire;

  always_comb begin
    // a new burst is only taken when nothing is outstanding (running or preempted)
    burst_acc = bus.burst_go && (bus.burst_len != 4'd0) && (rem_q == 4'd0);
    drop_d    = bus.burst_go && (rem_q != 4'd0);
    rem_eff   = burst_acc ? bus.burst_len : rem_q;

    // the timer only advances while nobody else owns the button; AUTO counts as
    // idle so consecutive pulses are exactly period+1 cycles apart
    auto_ok   = bus.auto_en && (bus.period != 8'd0);
    auto_win  = auto_ok && ((state_q == S_IDLE) || (state_q == S_AUTO));
    auto_fire = auto_win && (timer_q >= bus.period);

    state_d = S_IDLE;
    rem_d   = rem_eff;
    if (bus.man_req) begin
      state_d = S_MANUAL;                 // burst remainder stays frozen
    end else if (rem_eff != 4'd0) begin
      state_d = S_BURST;
      rem_d   = rem_eff - 4'd1;           // this cycle is one of the burst steps
    end else if (auto_fire) begin
      state_d = S_AUTO;
    end

    timer_d = timer_q;
    if (!auto_ok) begin
      timer_d = 8'd0;
    end else if (auto_win) begin
      if (auto_fire) begin
        // expiry lost to a higher-priority requester: hold at period so the
        // pulse goes out on the first cycle we are idle again
        if (state_d == S_AUTO) timer_d = 8'd0;
      end else begin
        timer_d = timer_q + 8'd1;
      end
    end

    button_d = (state_d != S_IDLE);
    busy_d   = (state_d != S_IDLE);
    step_d   = step_q + {7'd0, button_d};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      rem_q    <= 4'd0;
      timer_q  <= 8'd0;
      step_q   <= 8'd0;
      button_q <= 1'b0;
      busy_q   <= 1'b0;
      drop_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rem_q    <= rem_d;
      timer_q  <= timer_d;
      step_q   <= step_d;
      button_q <= button_d;
      busy_q   <= busy_d;
      drop_q   <= drop_d;
    end
  end

  assign bus.button     = button_q;
  assign bus.grant      = state_q;
  assign bus.busy       = busy_q;
  assign bus.burst_drop = drop_q;
  assign bus.step_cnt   = step_q;

endmodule

// File: tb/tb_lights_seq.sv
// Purpose: directed self-checking bench for lights_seq.
// Ports:   none; drives the DUT through a lights_seq_if instance.
//          Inputs change on negedge, outputs are checked on the next negedge.
module tb_lights_seq;
  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_pass;

  lights_seq_if bus ();

  lights_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // one clock later, compare button/grant/busy
  task automatic expect_cyc(input logic b, input logic [1:0] g, input string tag);
    @(negedge clk);
    chk({tag, ".button"}, {31'd0, bus.button}, {31'd0, b});
    chk({tag, ".grant"},  {30'd0, bus.grant},  {30'd0, g});
    chk({tag, ".busy"},   {31'd0, bus.busy},   {31'd0, (g != 2'b00)});
  endtask

  task automatic do_reset();
    bus.man_req   = 1'b0;
    bus.burst_go  = 1'b0;
    bus.burst_len = 4'd0;
    bus.auto_en   = 1'b0;
    bus.period    = 8'd0;
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;
    rst_n  = 1'b1;

    // reset state
    do_reset();
    chk("rst.button", {31'd0, bus.button}, 32'd0);
    chk("rst.grant", {30'd0, bus.grant}, 32'd0);
    chk("rst.busy", {31'd0, bus.busy}, 32'd0);
    chk("rst.drop", {31'd0, bus.burst_drop}, 32'd0);
    chk("rst.step_cnt", {24'd0, bus.step_cnt}, 32'd0);

    // manual for 5 cycles
    bus.man_req = 1'b1;
    for (int i = 0; i < 5; i++) expect_cyc(1'b1, 2'b01, "man");
    bus.man_req = 1'b0;
    expect_cyc(1'b0, 2'b00, "man.end");
    chk("man.step_cnt", {24'd0, bus.step_cnt}, 32'd5);

    // burst of 3
    do_reset();
    bus.burst_go = 1'b1; bus.burst_len = 4'd3;
    expect_cyc(1'b1, 2'b10, "b3.1");
    bus.burst_go = 1'b0;
    expect_cyc(1'b1, 2'b10, "b3.2");
    expect_cyc(1'b1, 2'b10, "b3.3");
    expect_cyc(1'b0, 2'b00, "b3.end");
    chk("b3.step_cnt", {24'd0, bus.step_cnt}, 32'd3);

    // burst of 6 preempted by 4 manual cycles after 2 steps
    do_reset();
    bus.burst_go = 1'b1; bus.burst_len = 4'd6;
    expect_cyc(1'b1, 2'b10, "pre.b1");
    bus.burst_go = 1'b0;
    expect_cyc(1'b1, 2'b10, "pre.b2");
    bus.man_req = 1'b1;
    for (int i = 0; i < 4; i++) expect_cyc(1'b1, 2'b01, "pre.man");
    bus.man_req = 1'b0;
    for (int i = 0; i < 4; i++) expect_cyc(1'b1, 2'b10, "pre.resume");
    expect_cyc(1'b0, 2'b00, "pre.end");
    chk("pre.step_cnt", {24'd0, bus.step_cnt}, 32'd10);

    // burst_go during an active burst is dropped, length unchanged
    do_reset();
    bus.burst_go = 1'b1; bus.burst_len = 4'd4;
    expect_cyc(1'b1, 2'b10, "drop.1");
    chk("drop.idle", {31'd0, bus.burst_drop}, 32'd0);
    bus.burst_go = 1'b0;
    expect_cyc(1'b1, 2'b10, "drop.2");
    bus.burst_go = 1'b1; bus.burst_len = 4'd9;
    expect_cyc(1'b1, 2'b10, "drop.3");
    chk("drop.pulse", {31'd0, bus.burst_drop}, 32'd1);
    bus.burst_go = 1'b0;
    expect_cyc(1'b1, 2'b10, "drop.4");
    chk("drop.clear", {31'd0, bus.burst_drop}, 32'd0);
    expect_cyc(1'b0, 2'b00, "drop.end");
    chk("drop.step_cnt", {24'd0, bus.step_cnt}, 32'd4);

    // burst_len=0 ignored silently
    bus.burst_go = 1'b1; bus.burst_len = 4'd0;
    expect_cyc(1'b0, 2'b00, "len0");
    chk("len0.drop", {31'd0, bus.burst_drop}, 32'd0);
    bus.burst_go = 1'b0;

    // auto period 4: pulse every 5 cycles; then period 0 disables
    do_reset();
    bus.auto_en = 1'b1; bus.period = 8'd4;
    for (int i = 0; i < 4; i++) expect_cyc(1'b0, 2'b00, "auto.wait1");
    expect_cyc(1'b1, 2'b11, "auto.p1");
    for (int i = 0; i < 4; i++) expect_cyc(1'b0, 2'b00, "auto.wait2");
    expect_cyc(1'b1, 2'b11, "auto.p2");
    bus.period = 8'd0;
    for (int i = 0; i < 12; i++) expect_cyc(1'b0, 2'b00, "auto.off");
    chk("auto.step_cnt", {24'd0, bus.step_cnt}, 32'd2);

    // auto expiry coinciding with manual is deferred to first idle cycle
    do_reset();
    bus.auto_en = 1'b1; bus.period = 8'd2;
    expect_cyc(1'b0, 2'b00, "defer.w1");
    expect_cyc(1'b0, 2'b00, "defer.w2");
    bus.man_req = 1'b1;
    expect_cyc(1'b1, 2'b01, "defer.m1");
    expect_cyc(1'b1, 2'b01, "defer.m2");
    bus.man_req = 1'b0;
    expect_cyc(1'b0, 2'b00, "defer.idle");
    expect_cyc(1'b1, 2'b11, "defer.auto");
    expect_cyc(1'b0, 2'b00, "defer.after");

    // asynchronous reset during a 15-step burst
    do_reset();
    bus.burst_go = 1'b1; bus.burst_len = 4'd15;
    expect_cyc(1'b1, 2'b10, "arst.b1");
    bus.burst_go = 1'b0;
    expect_cyc(1'b1, 2'b10, "arst.b2");
    #1 rst_n = 1'b0;
    #1;
    chk("arst.button", {31'd0, bus.button}, 32'd0);
    chk("arst.grant", {30'd0, bus.grant}, 32'd0);
    chk("arst.busy", {31'd0, bus.busy}, 32'd0);
    chk("arst.step_cnt", {24'd0, bus.step_cnt}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) expect_cyc(1'b0, 2'b00, "arst.after");

    // step_cnt wraps 255 -> 0
    do_reset();
    bus.man_req = 1'b1;
    for (int i = 0; i < 256; i++) @(negedge clk);
    chk("wrap.zero", {24'd0, bus.step_cnt}, 32'd0);
    @(negedge clk);
    chk("wrap.one", {24'd0, bus.step_cnt}, 32'd1);
    bus.man_req = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
